// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks: state encoding
// and the default bit timing derived from the board clock and baud rate.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int CLK_HZ       = 100_000_000;
    localparam int BAUD         = 115200;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter in the system clock domain. Counts 0..CLKS_PER_BIT-1
// and holds at the terminal count, where tick_o marks the end of a bit.
// The load port lets a receiver start mid-bit (half-bit preload).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clr_i,
    input  logic                              load_i,
    input  logic [$clog2(CLKS_PER_BIT)-1:0]   load_val_i,
    output logic                              tick_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count;

    assign tick_o = (count == CNT_W'(CLKS_PER_BIT - 1));

    // Counter: clear wins over preload; stops at terminal instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count <= '0;
        end else if (load_i) begin
            count <= load_val_i;
        end else if (!tick_o) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and sends it
// as start bit, DATA_BITS payload bits LSB first, then STOP_BITS stop bits.
// tx_o is registered from the next-state decode so the line changes on the
// same edge as the state register.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $fatal(1, "uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t       state, state_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic                 tx_next;
    logic                 done_next;
    logic                 bit_tick;
    logic                 timer_clr;

    // Every state change happens on a bit-end tick or on leaving IDLE, so
    // this clears the timer on each state entry and at each bit boundary.
    assign timer_clr = (state == IDLE) || bit_tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (timer_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .tick_o     (bit_tick)
    );

    assign ready_o = (state == IDLE);
    assign busy_o  = !ready_o;

    // Next-state, shift register, bit index and line-level decode.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    state_next   = START;
                    shift_next   = data_i;
                    bit_idx_next = '0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_next = shift >> 1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_next   = STOP;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        state_next   = IDLE;
                        bit_idx_next = '0;
                        done_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // Control state and registered outputs; reset abandons any frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            bit_idx <= '0;
            tx_o    <= 1'b1;
            done_o  <= 1'b0;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            tx_o    <= tx_next;
            done_o  <= done_next;
        end
    end

    // Payload shift register; only meaningful while a frame is in flight.
    always_ff @(posedge clk_i) begin
        shift <= shift_next;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at CLKS_PER_BIT=4 8N1 and one at
// CLKS_PER_BIT=2, 7 data bits, 2 stop bits. Expected line levels come from
// the frame layout (start, LSB-first payload, stop), decoded at bit centres.
module tb_uart_tx;

    localparam int CPB1 = 4, D1 = 8, S1 = 1;
    localparam int CPB2 = 2, D2 = 7, S2 = 2;

    logic clk_out1 = 1'b0;
    always #5 clk_out1 = ~clk_out1;

    logic         rst;
    logic [7:0]   data1;
    logic         valid1;
    logic         ready1, tx1, busy1, done1;
    logic [6:0]   data2;
    logic         valid2;
    logic         ready2, tx2, busy2, done2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int dcnt1   = 0;
    int dcnt2   = 0;

    uart_tx #(.CLKS_PER_BIT(CPB1), .DATA_BITS(D1), .STOP_BITS(S1)) u_dut (
        .clk_i   (clk_out1),
        .rst_i   (rst),
        .data_i  (data1),
        .valid_i (valid1),
        .ready_o (ready1),
        .tx_o    (tx1),
        .busy_o  (busy1),
        .done_o  (done1)
    );

    uart_tx #(.CLKS_PER_BIT(CPB2), .DATA_BITS(D2), .STOP_BITS(S2)) u_dut2 (
        .clk_i   (clk_out1),
        .rst_i   (rst),
        .data_i  (data2),
        .valid_i (valid2),
        .ready_o (ready2),
        .tx_o    (tx2),
        .busy_o  (busy2),
        .done_o  (done2)
    );

    // Cycle counter and done_o pulse counters.
    always @(posedge clk_out1) begin
        cyc <= cyc + 1;
        if (done1 === 1'b1) dcnt1 <= dcnt1 + 1;
        if (done2 === 1'b1) dcnt2 <= dcnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_out1);
        #1;
    endtask

    // {tx, ready, busy, done} of the selected instance
    function automatic logic [3:0] obs(input bit sel);
        return sel ? {tx2, ready2, busy2, done2} : {tx1, ready1, busy1, done1};
    endfunction

    // Called just after the accept edge; walks the whole frame, then checks
    // the done/ready cycle that follows the last stop-bit cycle.
    task automatic check_frame(input string tag, input bit sel, input logic [7:0] b,
                               input bit toggle);
        int cpb, d, s, f;
        logic [7:0] got;
        logic [3:0] o;
        logic line;
        cpb = sel ? CPB2 : CPB1;
        d   = sel ? D2 : D1;
        s   = sel ? S2 : S1;
        f   = (1 + d + s) * cpb;
        got = '0;
        for (int c = 0; c < f; c++) begin
            int pos;
            pos = c / cpb;
            if (pos == 0)      line = 1'b0;
            else if (pos <= d) line = b[pos-1];
            else               line = 1'b1;
            o = obs(sel);
            check({tag, "_line"}, {28'd0, o}, {28'd0, line, 3'b010});
            if ((c % cpb) == (cpb / 2) && pos >= 1 && pos <= d) got[pos-1] = o[3];
            if (toggle) begin
                if (sel) data2 = ~data2;
                else     data1 = ~data1;
            end
            step();
        end
        check({tag, "_decode"}, {24'd0, got}, {24'd0, b});
        check({tag, "_done"}, {28'd0, obs(sel)}, 32'h0000_000D);
    endtask

    initial begin
        int t0, d0;
        rst    = 1'b1;
        data1  = 8'h00;
        valid1 = 1'b0;
        data2  = 7'h00;
        valid2 = 1'b0;

        // 1: reset held three cycles, then idle
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset", {28'd0, obs(0)}, 32'hC);
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle", {28'd0, obs(0)}, 32'hC);
        end

        // 2: single byte 0xA5
        data1 = 8'hA5; valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        check_frame("a5", 0, 8'hA5, 0);
        step();
        check("a5_after", {28'd0, obs(0)}, 32'hC);

        // 3: back-to-back 0x00 then 0xFF with valid held high
        d0 = dcnt1;
        data1 = 8'h00; valid1 = 1'b1;
        step();
        t0 = cyc;
        data1 = 8'hFF;
        check_frame("b2b0", 0, 8'h00, 0);
        step();
        valid1 = 1'b0;
        check_frame("b2b1", 0, 8'hFF, 0);
        check("b2b_len", cyc - t0 + 1, 82);
        step();
        check("b2b_dones", dcnt1 - d0, 2);

        // 4: data_i toggling during the frame is ignored
        for (int i = 0; i < 3; i++) step();
        data1 = 8'h3C; valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        check_frame("stall", 0, 8'h3C, 1);
        step();

        // 5: reset during data bit 3 of 0xF0 (bit 3 is low)
        data1 = 8'hF0; valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        for (int i = 0; i < 17; i++) step();
        check("rst_pre_tx", {31'd0, tx1}, 32'd0);
        d0  = dcnt1;
        rst = 1'b1;
        step();
        check("rst_mid", {28'd0, obs(0)}, 32'hC);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("rst_idle", {28'd0, obs(0)}, 32'hC);
        end
        check("rst_no_done", dcnt1 - d0, 0);
        data1 = 8'h81; valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        check_frame("after_rst", 0, 8'h81, 0);
        step();

        // 6: 7 data bits, 2 stop bits, 2 clocks per bit, 0x55
        d0 = dcnt2;
        data2 = 7'h55; valid2 = 1'b1;
        step();
        t0 = cyc;
        valid2 = 1'b0;
        check_frame("cfg", 1, 8'h55, 0);
        check("cfg_len", cyc - t0, 20);
        step();
        check("cfg_after", {28'd0, obs(1)}, 32'hC);
        check("cfg_dones", dcnt2 - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter (8N1 by default) that serialises samples and status words from the FIR/control datapath onto the board's UART TX pin. Each byte enters through a valid/ready handshake, and bit timing comes from an internal baud counter in the system clock domain. It is the transmitting end of the UART link whose bit rate the clock block sets, and it uses a clock-enable counter instead of a divided clock.

## Interface
- CLKS_PER_BIT, 868, system-clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2
- DATA_BITS, 8, payload bits per frame; legal range 5–9
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2
- clk_i  in  1  system clock; all logic is on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- data_i  in  DATA_BITS  byte to send; sampled only on an accepted handshake
- valid_i  in  1  data_i holds a byte
- ready_o  out  1  block can accept a byte; high only in IDLE
- tx_o  out  1  serial line; idles high; registered
- busy_o  out  1  a frame is in progress; equals !ready_o
- done_o  out  1  one-cycle pulse marking the end of the last stop bit

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx_o=1, ready_o=1.
  - Accept occurs when valid_i && ready_o && !rst_i at a rising edge.
  - On accept: latch data_i into the shift register, clear the bit timer and bit index, go to START.
- START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx_o = shift[0], so bits go out LSB first.
  - Each bit lasts CLKS_PER_BIT cycles; the register shifts right at the end of each bit.
  - After DATA_BITS bits, go to STOP.
- STOP: tx_o=1 for STOP_BITS×CLKS_PER_BIT cycles, then return to IDLE and pulse done_o.
- Bit timer:
  - Counts 0..CLKS_PER_BIT−1; the terminal count is the bit-end strobe.
  - Width is $clog2(CLKS_PER_BIT).
  - Bit index width is $clog2(DATA_BITS+1).
  - Neither counter wraps past terminal; both are cleared on every state entry.
- data_i changes while not in IDLE are ignored; the byte is frozen at accept.
- Reset:
  - Takes effect at the first rising edge with rst_i=1.
  - State goes to IDLE; tx_o=1, ready_o=1, busy_o=0, done_o=0.
  - A frame interrupted by reset is abandoned: tx_o goes high at that edge and no done_o is issued.
- A handshake presented while rst_i=1 is ignored.

## Timing
- Accept at edge N:
  - tx_o is low from edge N+1; the start bit occupies cycles N+1..N+CLKS_PER_BIT.
  - Data bit k occupies cycles N+1+(1+k)·CLKS_PER_BIT .. N+(2+k)·CLKS_PER_BIT.
- Let F = (1+DATA_BITS+STOP_BITS)·CLKS_PER_BIT.
  - done_o=1 and ready_o=1 in the cycle following edge N+F; the last stop-bit cycle is N+F.
- Back-to-back:
  - If valid_i is high when ready_o returns, the next accept happens at that edge.
  - The next start bit follows with no extra idle; frame period = F+1 cycles.
- done_o and the next accept can coincide in the same cycle.
- All outputs are registered or decoded directly from the state register; there is no combinational path from valid_i or data_i to any output.

## Structure
- Package uart_pkg holds:
  - the state enum `uart_tx_state_t` {IDLE, START, DATA, STOP};
  - the localparam defaults CLK_HZ=100_000_000, BAUD=115200, and the derived CLKS_PER_BIT.
- A sub-module uart_bit_timer (counter plus terminal strobe, with a clear input) is natural.
  - The future uart_rx will reuse it with a half-bit preload.
- Elaboration-time assertions check the parameter legal ranges.

## Test plan
1. Reset then idle:
   - Stimulus: hold rst_i for 3 cycles, release, keep valid_i low for 50 cycles.
   - Required: tx_o=1, ready_o=1, busy_o=0, done_o=0 throughout.
2. Single byte:
   - Stimulus: CLKS_PER_BIT=4, send 0xA5.
   - Required: tx_o is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
   - Required: done_o pulses exactly 41 cycles after accept.
3. Back-to-back:
   - Stimulus: valid_i held high with 0x00 then 0xFF.
   - Required: second start bit begins the cycle after the first done_o; 82 cycles total; exactly 2 done_o pulses.
4. Stall:
   - Stimulus: toggle data_i every cycle during a frame carrying 0x3C.
   - Required: decoded line still equals 0x3C; ready_o=0 for the whole frame.
5. Reset mid-frame:
   - Stimulus: assert rst_i during data bit 3.
   - Required: tx_o=1 at that edge, no done_o; the next frame with byte 0x81 is transmitted correctly.
6. Config sweep:
   - Stimulus: STOP_BITS=2, DATA_BITS=7, CLKS_PER_BIT=2, send 0x55.
   - Required: frame length 20 cycles; stop high for 4 cycles; checked by a line-decoding reference monitor.
